seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle signed 32-bit integer divider for the MIPS datapath (DIV). It is the
//  inverse of the Booth multiplier and shares its HI/LO output convention.
//  A start pulse latches dividend A and divisor B. After WIDTH iterations of restoring
//  shift-subtract, the quotient goes to low (LO) and the remainder to high (HI).
//  The control unit holds the FSM in a wait state until done pulses.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  A         in   WIDTH  signed dividend
//  B         in   WIDTH  signed divisor
//  high      out  WIDTH  remainder (HI), registered
//  low       out  WIDTH  quotient (LO), registered
//  busy      out  1      high in CALC and DONE states
//  done      out  1      one-cycle pulse: results valid/updated
//  div_zero  out  1      set with done when B==0; cleared on next accepted start
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; high=low=0; busy=done=div_zero=0; count=0; internal regs=0.
//  States:
//  - IDLE: if start=1, latch |A|, |B|, sign_q=A[31]^B[31], sign_r=A[31], and clear div_zero.
//    - If B==0: go to DONE with zflag.
//    - Else: go to CALC with count=0 and partial remainder R=0 (WIDTH+1 bits).
//  - CALC: each cycle, shift {R,Q} left 1 with the dividend MSB entering R.
//    - If R>=|B|: R=R-|B| and Q[0]=1; else Q[0]=0.
//    - count++. When count==WIDTH-1 (final iteration), go to DONE.
//  - DONE: one cycle. done=1, then always return to IDLE.
//    - Normal: low = sign_q ? -Q : Q; high = sign_r ? -R : R.
//    - Zero divisor: div_zero=1; high/low keep their previous values.
//  Latency:
//  - Normal: start sampled at edge E0; done=1 in the cycle after edge E0+WIDTH (WIDTH+1 cycles).
//  - B==0: done=1 in the cycle after E0+1.
//  Arithmetic rules:
//  - Truncating division toward zero; the remainder takes the dividend's sign (MIPS semantics).
//  - Magnitudes are unsigned WIDTH bits, so |0x80000000| = 2^31 is exact.
//  - 0x80000000 / -1 gives low=0x80000000, high=0. No trap, no flag.
//  Boundary conditions:
//  - start while busy=1: ignored; operands are not re-latched.
//  - A and B may change after the start cycle without affecting the result.
//  - high/low are stable outside DONE; they update only on the DONE edge.
//  - Reset mid-CALC: immediate return to reset values; no done pulse.
//  - start held high continuously: a new operation begins the cycle after done (IDLE re-samples).
// TESTING
//  - A=7, B=2, start 1 cycle -> done after 33 cycles; low=3, high=1, div_zero=0.
//  - A=-7 (0xFFFFFFF9), B=2 -> low=0xFFFFFFFD (-3), high=0xFFFFFFFF (-1).
//  - A=7, B=-2 -> low=-3, high=1. A=-7, B=-2 -> low=3, high=-1.
//  - Prior result low=3, high=1; then A=5, B=0 -> done after 2 cycles; div_zero=1; low=3, high=1 unchanged.
//  - A=0x80000000, B=0xFFFFFFFF -> low=0x80000000, high=0. A=0, B=9 -> low=0, high=0.
//  - Assert rst=0 at cycle 10 of CALC -> high=low=0, busy=0, no done.
//  - A second start pulse at cycle 5 with other operands -> first result is unaffected.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: quotient on low (LO), remainder on high (HI).
// Truncates toward zero; the remainder carries the dividend's sign.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] high,
    output logic [WIDTH-1:0] low,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshake: start is sampled only while idle (busy=0); done is high for exactly
    // one cycle, during which high/low/div_zero already hold the new result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_sub;
    logic             fits;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_final;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) exactly.
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    assign r_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign r_sub   = r_shift - {1'b0, bmag_q};
    assign fits    = (r_shift >= {1'b0, bmag_q});
    assign r_next  = fits ? r_sub : r_shift;
    assign q_next  = {quo_q[WIDTH-2:0], fits};
    assign r_final = r_next[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        bmag_d     = bmag_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        high_d     = high_q;
        low_d      = low_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bmag_d     = b_mag;
                    quo_d      = a_mag;
                    rem_d      = '0;
                    count_d    = '0;
                    sign_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
                    sign_rem_d = A[WIDTH-1];
                    div_zero_d = 1'b0;
                    state_d    = (B == '0) ? S_ZERO : S_CALC;
                end
            end
            S_CALC: begin
                rem_d   = r_next;
                quo_d   = q_next;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    low_d   = sign_quo_q ? -q_next : q_next;
                    high_d  = sign_rem_q ? -r_final : r_final;
                end
            end
            // Zero divisor spends one extra cycle so done lands two cycles after start.
            S_ZERO: begin
                state_d    = S_DONE;
                done_d     = 1'b1;
                div_zero_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            bmag_q     <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            high_q     <= '0;
            low_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            bmag_q     <= bmag_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            high_q     <= high_d;
            low_q      <= low_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign high        = high_q;
    assign low         = low_q;
    assign done        = done_q;
    assign div_zero    = div_zero_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table of signed divisions plus
// hand sequences for held start, start while busy and reset during calculation.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] high;
    logic [31:0] low;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .high       (high),
        .low        (low),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts rising edges from the start-sampling edge until done is seen (negedge sampling).
    // drop_at: cycle after which start is released and operands scrambled (0 = never).
    // pulse_at: cycle after which a second start pulse with other operands is issued (0 = none).
    task automatic wait_done(input int drop_at, input int pulse_at, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == drop_at) begin
                start = 1'b0;
                A = $urandom;
                B = $urandom_range(1, 1000);
            end
            if (pulse_at != 0 && i == pulse_at) begin
                start = 1'b1;
                A = 32'd9;
                B = 32'd3;
            end
            if (pulse_at != 0 && i == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc;
        @(negedge clk);
        A = v.a;
        B = v.b;
        start = 1'b1;
        exp_q.push_back(v.lo);
        exp_q.push_back(v.hi);
        wait_done(1, 0, cyc);
        check({nm, "_latency"}, cyc, v.lat);
        check({nm, "_low"}, low, exp_q.pop_front());
        check({nm, "_high"}, high, exp_q.pop_front());
        check({nm, "_div_zero"}, div_zero, v.dz);
        check({nm, "_busy_in_done"}, busy, 1'b1);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 1'b0);
        check({nm, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int extra_done;

        vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33};
        vecs[1]  = '{32'd5,        32'd0,        32'd3,        32'd1,        1'b1, 2};
        vecs[2]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        vecs[3]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
        vecs[4]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 33};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
        vecs[6]  = '{32'd0,        32'd9,        32'd0,        32'd0,        1'b0, 33};
        vecs[7]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
        vecs[8]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
        vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 33};
        vecs[10] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 33};
        vecs[11] = '{32'h12345678, 32'd1000,     32'h0004A90B, 32'h00000380, 1'b0, 33};

        rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        check("reset_high", high, 32'd0);
        check("reset_low", low, 32'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_div_zero", div_zero, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse while busy must not re-latch operands or trigger a second run.
        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        wait_done(1, 5, cyc);
        check("busy_start_latency", cyc, 33);
        check("busy_start_low", low, 32'd14);
        check("busy_start_high", high, 32'd2);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("busy_start_no_rerun", extra_done, 0);

        // Start held high: IDLE re-samples the cycle after done.
        @(negedge clk);
        A = 32'd20;
        B = 32'd6;
        start = 1'b1;
        wait_done(0, 0, cyc);
        check("held_first_latency", cyc, 33);
        check("held_first_low", low, 32'd3);
        check("held_first_high", high, 32'd2);
        A = 32'd21;
        wait_done(2, 0, cyc);
        check("held_second_latency", cyc, 34);
        check("held_second_low", low, 32'd3);
        check("held_second_high", high, 32'd3);

        // Reset in the middle of a calculation.
        @(negedge clk);
        A = 32'd1000;
        B = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_high", high, 32'd0);
        check("midreset_low", low, 32'd0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("midreset_quiet", extra_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
